// File: rtl/stream_copy_pkg.sv
// Shared types and width helpers for the stream_copy engine.
package stream_copy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Width of a counter that must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/copy_fifo_buf.sv
// Power-of-two synchronous FIFO holding read data until the destination accepts it.
module copy_fifo_buf
    import stream_copy_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    localparam int PTR_W     = $clog2(FIFO_DEPTH),
    localparam int OCC_W     = cnt_w(FIFO_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              empty,
    output logic [OCC_W-1:0]  occ
);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        occ_d    = occ_q + OCC_W'(push) - OCC_W'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage needs no reset: emptiness is carried entirely by occ_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign empty = (occ_q == '0);
    assign occ   = occ_q;

endmodule

// File: rtl/stream_copy.sv
// Memory-to-memory streaming copy engine with credit-limited reads and write back-pressure.
//   state   | meaning
//   IDLE    | waiting for tstart; bases and length latched on launch
//   RUN     | issuing reads and draining the buffer into the destination
//   DONE    | one-cycle tdone pulse, then back to IDLE
module stream_copy
    import stream_copy_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 8,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tstart,
    input  logic [ADDR_W-1:0] tsrc,
    input  logic [ADDR_W-1:0] tdst,
    input  logic [ADDR_W:0]   tlen,
    output logic              tbusy,
    output logic              tdone,
    output logic [ADDR_W-1:0] v0_addr,
    output logic              v0_rd_en,
    input  logic [DATA_W-1:0] v0_rd_data,
    output logic [ADDR_W-1:0] v1_addr,
    output logic              v1_wr_en,
    output logic [DATA_W-1:0] v1_wr_data,
    input  logic              v1_wr_ready
);

    localparam int            CNT_W   = cnt_w(FIFO_DEPTH);
    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   src_q, src_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [ADDR_W:0]     rd_rem_q, rd_rem_d;
    logic [ADDR_W:0]     wr_rem_q, wr_rem_d;
    logic [RD_LAT-1:0]   vld_q, vld_d;

    logic                rd_issue;
    logic                wr_accept;
    logic                buf_push;
    logic                buf_empty;
    logic [DATA_W-1:0]   buf_head;
    logic [CNT_W-1:0]    buf_occ;
    logic [CNT_W-1:0]    inflight;
    logic [CNT_W-1:0]    outstanding;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CNT_W'(vld_q[i]);
        end
    end

    // Every issued read owns a buffer slot until its write is accepted.
    assign outstanding = buf_occ + inflight;
    assign rd_issue    = (state_q == ST_RUN) && (rd_rem_q != '0)
                         && (outstanding < CNT_W'(FIFO_DEPTH));
    assign wr_accept   = (state_q == ST_RUN) && !buf_empty && v1_wr_ready;
    assign buf_push    = vld_q[RD_LAT-1];
    assign vld_d       = RD_LAT'({vld_q, rd_issue});

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        rd_rem_d = rd_rem_q;
        wr_rem_d = wr_rem_q;
        case (state_q)
            ST_IDLE: begin
                if (tstart) begin
                    src_d    = tsrc;
                    dst_d    = tdst;
                    rd_rem_d = tlen;
                    wr_rem_d = tlen;
                    state_d  = (tlen == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (rd_issue) begin
                    src_d    = src_q + ADDR_W'(1);
                    rd_rem_d = rd_rem_q - LEN_ONE;
                end
                if (wr_accept) begin
                    dst_d    = dst_q + ADDR_W'(1);
                    wr_rem_d = wr_rem_q - LEN_ONE;
                    if (wr_rem_q == LEN_ONE) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            rd_rem_q <= '0;
            wr_rem_q <= '0;
            vld_q    <= '0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            rd_rem_q <= rd_rem_d;
            wr_rem_q <= wr_rem_d;
            vld_q    <= vld_d;
        end
    end

    copy_fifo_buf #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (buf_push),
        .push_data (v0_rd_data),
        .pop       (wr_accept),
        .head      (buf_head),
        .empty     (buf_empty),
        .occ       (buf_occ)
    );

    assign tbusy      = (state_q != ST_IDLE);
    assign tdone      = (state_q == ST_DONE);
    assign v0_addr    = src_q;
    assign v0_rd_en   = rd_issue;
    assign v1_addr    = dst_q;
    assign v1_wr_en   = (state_q == ST_RUN) && !buf_empty;
    // Buffer storage is unreset, so hide it while no write is presented.
    assign v1_wr_data = v1_wr_en ? buf_head : '0;

endmodule

// File: tb/tb_stream_copy.sv
// Directed scoreboard bench for stream_copy: default instance (a) and RD_LAT=3/FIFO_DEPTH=8 instance (b).
module tb_stream_copy;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        a_tstart, a_tbusy, a_tdone, a_rd_en, a_wr_en, a_ready;
    logic [7:0]  a_tsrc, a_tdst, a_v0_addr, a_v1_addr;
    logic [8:0]  a_tlen;
    logic [31:0] a_rd_data, a_wr_data;

    logic        b_tstart, b_tbusy, b_tdone, b_rd_en, b_wr_en, b_ready;
    logic [7:0]  b_tsrc, b_tdst, b_v0_addr, b_v1_addr;
    logic [8:0]  b_tlen;
    logic [31:0] b_rd_data, b_wr_data;

    stream_copy u_a (
        .clk(clk), .rst_n(rst_n), .tstart(a_tstart), .tsrc(a_tsrc), .tdst(a_tdst),
        .tlen(a_tlen), .tbusy(a_tbusy), .tdone(a_tdone), .v0_addr(a_v0_addr),
        .v0_rd_en(a_rd_en), .v0_rd_data(a_rd_data), .v1_addr(a_v1_addr),
        .v1_wr_en(a_wr_en), .v1_wr_data(a_wr_data), .v1_wr_ready(a_ready)
    );

    stream_copy #(.RD_LAT(3), .FIFO_DEPTH(8)) u_b (
        .clk(clk), .rst_n(rst_n), .tstart(b_tstart), .tsrc(b_tsrc), .tdst(b_tdst),
        .tlen(b_tlen), .tbusy(b_tbusy), .tdone(b_tdone), .v0_addr(b_v0_addr),
        .v0_rd_en(b_rd_en), .v0_rd_data(b_rd_data), .v1_addr(b_v1_addr),
        .v1_wr_en(b_wr_en), .v1_wr_data(b_wr_data), .v1_wr_ready(b_ready)
    );

    // Source memories: word at address x holds {tag, x}; tag changes between runs.
    logic [23:0] tag;
    logic [31:0] b_p1, b_p2;

    function automatic logic [31:0] srcval(input logic [23:0] t, input logic [7:0] a);
        return {t, a};
    endfunction

    always @(posedge clk) begin
        if (a_rd_en) a_rd_data <= srcval(tag, a_v0_addr);
        b_p1      <= srcval(tag, b_v0_addr);
        b_p2      <= b_p1;
        b_rd_data <= b_p2;
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic rnd  = 1'b0;

    logic [39:0] wq_a[$], wq_b[$];
    logic [7:0]  rq_a[$], rq_b[$];

    int   iss[2], acc[2], nwr[2], nrd[2], nbusy[2];
    int   first_wr[2], last_wr[2], done_cyc[2], l0[2];
    logic prev_stall[2];
    logic [7:0]  prev_addr[2];
    logic [31:0] prev_data[2];

    task automatic chk(input string tag_s, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag_s, got, exp);
        end
    endtask

    task automatic mon(input int u, input int depth, input logic ts, input logic bsy,
                       input logic dn, input logic re, input logic [7:0] ra,
                       input logic we, input logic rdy, input logic [7:0] wa,
                       input logic [31:0] wd);
        int rel;
        logic [7:0]  exp_r;
        logic [39:0] exp_w;
        if (ts && !bsy) begin
            iss[u] = 0; acc[u] = 0; nwr[u] = 0; nrd[u] = 0; nbusy[u] = 0;
            first_wr[u] = -1; last_wr[u] = -1; done_cyc[u] = -1;
            l0[u] = cyc + 1; prev_stall[u] = 1'b0;
        end
        rel = cyc - l0[u] + 1;
        chk("credit", 64'((iss[u] - acc[u] + int'(re)) <= depth), 64'd1);
        if (prev_stall[u])
            chk("stall_hold", 64'({we, wa, wd}), 64'({1'b1, prev_addr[u], prev_data[u]}));
        if (re) begin
            exp_r = 8'hxx;
            if (u == 0 && rq_a.size() > 0) exp_r = rq_a.pop_front();
            if (u == 1 && rq_b.size() > 0) exp_r = rq_b.pop_front();
            chk("rd_addr", 64'(ra), 64'(exp_r));
            nrd[u]++;
            iss[u]++;
        end
        if (we && rdy) begin
            exp_w = 40'hxx_xxxx_xxxx;
            if (u == 0 && wq_a.size() > 0) exp_w = wq_a.pop_front();
            if (u == 1 && wq_b.size() > 0) exp_w = wq_b.pop_front();
            chk("wr_addr_data", 64'({wa, wd}), 64'(exp_w));
            if (first_wr[u] < 0) first_wr[u] = rel;
            last_wr[u] = rel;
            nwr[u]++;
            acc[u]++;
        end
        if (dn) done_cyc[u] = rel;
        if (bsy) nbusy[u]++;
        prev_stall[u] = we && !rdy;
        prev_addr[u]  = wa;
        prev_data[u]  = wd;
    endtask

    task automatic step();
        @(negedge clk);
        mon(0, 4, a_tstart, a_tbusy, a_tdone, a_rd_en, a_v0_addr, a_wr_en, a_ready, a_v1_addr, a_wr_data);
        mon(1, 8, b_tstart, b_tbusy, b_tdone, b_rd_en, b_v0_addr, b_wr_en, b_ready, b_v1_addr, b_wr_data);
        @(posedge clk);
        #1;
        cyc++;
        a_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic launch_a(input logic [7:0] s, input logic [7:0] d, input logic [8:0] n);
        a_tsrc = s; a_tdst = d; a_tlen = n; a_tstart = 1'b1;
        for (int i = 0; i < int'(n); i++) begin
            rq_a.push_back(s + 8'(i));
            wq_a.push_back({d + 8'(i), srcval(tag, s + 8'(i))});
        end
        step();
        a_tstart = 1'b0;
        a_tsrc = 8'($urandom); a_tdst = 8'($urandom); a_tlen = 9'($urandom);
    endtask

    task automatic launch_b(input logic [7:0] s, input logic [7:0] d, input logic [8:0] n);
        b_tsrc = s; b_tdst = d; b_tlen = n; b_tstart = 1'b1;
        for (int i = 0; i < int'(n); i++) begin
            rq_b.push_back(s + 8'(i));
            wq_b.push_back({d + 8'(i), srcval(tag, s + 8'(i))});
        end
        step();
        b_tstart = 1'b0;
    endtask

    task automatic wait_done(input int u, input int lim);
        int k = 0;
        while (done_cyc[u] < 0 && k < lim) begin
            step();
            k++;
        end
        chk("done_seen", 64'(done_cyc[u] >= 0), 64'd1);
        step();
        step();
    endtask

    initial begin
        rst_n = 1'b0; tag = '0;
        a_tstart = 0; a_tsrc = 0; a_tdst = 0; a_tlen = 0; a_ready = 1'b1;
        b_tstart = 0; b_tsrc = 0; b_tdst = 0; b_tlen = 0; b_ready = 1'b1;
        for (int u = 0; u < 2; u++) begin
            iss[u] = 0; acc[u] = 0; nwr[u] = 0; nrd[u] = 0; nbusy[u] = 0;
            first_wr[u] = -1; last_wr[u] = -1; done_cyc[u] = -1; l0[u] = 0;
            prev_stall[u] = 1'b0; prev_addr[u] = '0; prev_data[u] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("reset_a_outputs", 64'({a_tbusy, a_tdone, a_rd_en, a_wr_en, a_v0_addr, a_v1_addr, a_wr_data}), 64'd0);
        chk("reset_b_outputs", 64'({b_tbusy, b_tdone, b_rd_en, b_wr_en, b_v0_addr, b_v1_addr, b_wr_data}), 64'd0);
        rst_n = 1'b1;
        step();

        // Basic copy: writes 16..19 carry 0..3 in cycles 3..6, tdone in cycle 7.
        launch_a(8'd0, 8'd16, 9'd4);
        wait_done(0, 50);
        chk("basic_first_wr", 64'(first_wr[0]), 64'd3);
        chk("basic_last_wr", 64'(last_wr[0]), 64'd6);
        chk("basic_nwr", 64'(nwr[0]), 64'd4);
        chk("basic_nrd", 64'(nrd[0]), 64'd4);
        chk("basic_done", 64'(done_cyc[0]), 64'd7);
        chk("basic_sb_empty", 64'(wq_a.size()), 64'd0);

        // Zero length: tdone in cycle 1, no strobes, one busy cycle.
        launch_a(8'd9, 8'd77, 9'd0);
        wait_done(0, 20);
        chk("zero_done", 64'(done_cyc[0]), 64'd1);
        chk("zero_nrd", 64'(nrd[0]), 64'd0);
        chk("zero_nwr", 64'(nwr[0]), 64'd0);
        chk("zero_busy", 64'(nbusy[0]), 64'd1);

        // Long latency instance: writes in cycles 5..14, tdone in cycle 15.
        tag = 24'h000001;
        launch_b(8'd32, 8'd96, 9'd10);
        wait_done(1, 60);
        chk("lat3_first_wr", 64'(first_wr[1]), 64'd5);
        chk("lat3_last_wr", 64'(last_wr[1]), 64'd14);
        chk("lat3_nwr", 64'(nwr[1]), 64'd10);
        chk("lat3_done", 64'(done_cyc[1]), 64'd15);
        chk("lat3_sb_empty", 64'(wq_b.size()), 64'd0);

        // Random destination back-pressure.
        tag = 24'h000002;
        rnd = 1'b1;
        launch_a(8'h40, 8'h80, 9'd32);
        wait_done(0, 400);
        rnd = 1'b0;
        chk("bp_nwr", 64'(nwr[0]), 64'd32);
        chk("bp_nrd", 64'(nrd[0]), 64'd32);
        chk("bp_sb_empty", 64'(wq_a.size()), 64'd0);

        // Address wrap on both ports.
        tag = 24'h000003;
        launch_a(8'd254, 8'd255, 9'd3);
        wait_done(0, 30);
        chk("wrap_nwr", 64'(nwr[0]), 64'd3);
        chk("wrap_rq_empty", 64'(rq_a.size()), 64'd0);
        chk("wrap_sb_empty", 64'(wq_a.size()), 64'd0);

        // Reset in cycle 4 of an 8-word run, then a fresh 2-word copy.
        tag = 24'h000004;
        launch_a(8'd0, 8'd16, 9'd8);
        step(); step(); step();
        chk("pre_reset_active", 64'(a_wr_en), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_outputs", 64'({a_tbusy, a_tdone, a_rd_en, a_wr_en, a_v0_addr, a_v1_addr, a_wr_data}), 64'd0);
        step();
        step();
        rq_a.delete();
        wq_a.delete();
        rst_n = 1'b1;
        tag = 24'h000005;
        step();
        launch_a(8'd8, 8'd40, 9'd2);
        wait_done(0, 30);
        chk("fresh_nwr", 64'(nwr[0]), 64'd2);
        chk("fresh_done", 64'(done_cyc[0]), 64'd5);
        chk("fresh_sb_empty", 64'(wq_a.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_copy.md
# stream_copy

Parametrised memory-to-memory streaming copy engine: the next generation of the single-shot HIR `fifo` copier. Reads `tlen` words from a source memory port starting at `tsrc` and writes them in order to a destination memory port starting at `tdst`. Supports configurable read latency, destination back-pressure, and a done/busy handshake. Sits between two external SRAM-style ports and is launched by a one-cycle `tstart` pulse from the HIR schedule controller.

## Interface
- `DATA_W`, 32, word width
- `ADDR_W`, 8, address width; addresses wrap modulo 2^ADDR_W
- `RD_LAT`, 1, source read latency in cycles, ≥1
- `FIFO_DEPTH`, 4, internal buffer depth; power of 2; ≥ RD_LAT+1 (legal), ≥ RD_LAT+2 (full rate)

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `tstart` in 1: launch pulse, sampled in IDLE only
- `tsrc` in ADDR_W: source base, latched on launch
- `tdst` in ADDR_W: destination base, latched on launch
- `tlen` in ADDR_W+1: word count 0..2^ADDR_W, latched on launch
- `tbusy` out 1: high from the cycle after launch until `tdone`, inclusive of `tdone`
- `tdone` out 1: one-cycle completion pulse
- `v0_addr` out ADDR_W: source address
- `v0_rd_en` out 1: source read strobe
- `v0_rd_data` in DATA_W: valid RD_LAT cycles after `v0_rd_en`
- `v1_addr` out ADDR_W: destination address
- `v1_wr_en` out 1: destination write strobe
- `v1_wr_data` out DATA_W: destination data
- `v1_wr_ready` in 1: destination accepts when high; a write occurs in any cycle with `v1_wr_en & v1_wr_ready`

## Operation
- States: IDLE, RUN, DONE.
- IDLE: on `tstart`, latch `tsrc`/`tdst`/`tlen`. If `tlen`==0, go to DONE; otherwise go to RUN.
- RUN, read side: issue `v0_rd_en` with `v0_addr`=src counter while reads remaining > 0 and occupancy + in-flight < FIFO_DEPTH. Each issue increments the src counter, with wrap.
- In-flight tracking: a RD_LAT-deep valid shift register. A valid bit exiting it pushes `v0_rd_data` into the buffer. The credit rule guarantees no overflow.
- RUN, write side: `v1_wr_en` = buffer non-empty. `v1_wr_data` = buffer head; `v1_addr` = dst counter. On an accepted write, pop and increment dst (with wrap). `v1_wr_en` stays high with stable addr/data while `v1_wr_ready` is low.
- RUN → DONE when the last write is accepted.
- DONE: `tdone`=1 for one cycle, then IDLE.
- `tstart` outside IDLE is ignored. Inputs `tsrc`/`tdst`/`tlen` are don't-care outside the launch cycle.
- Reset, including mid-operation, aborts immediately. In-flight read data is discarded. The buffer is emptied.

## Timing
- Reset values: all outputs 0; state IDLE.
- Launch: `tstart` sampled at edge E0; first `v0_rd_en` in cycle 1.
- Read latency: data for a read issued in cycle k is captured at the end of cycle k+RD_LAT. Its write is presented from cycle k+RD_LAT+1.
- Full rate: with `v1_wr_ready`=1 and FIFO_DEPTH ≥ RD_LAT+2, one word per cycle.
  - Writes occupy cycles RD_LAT+2 .. RD_LAT+N+1.
  - `tdone` falls in cycle RD_LAT+N+2.
- `tlen`=0: `tdone` in cycle 1. No `v0_rd_en` or `v1_wr_en` is asserted.
- Back-pressure: reads stall once occupancy + in-flight = FIFO_DEPTH. Reads resume the cycle after a pop frees a slot.
- Wrap: address 2^ADDR_W−1 is followed by 0 on both ports.

## Structure
- Package `stream_copy_pkg`: state enum (IDLE/RUN/DONE) and a `clog2`-based width constant helper.
- Sub-module `copy_fifo_buf`: synchronous FIFO with the following characteristics:
  - parameters DATA_W and FIFO_DEPTH;
  - push/pop, head data, and occupancy outputs;
  - async active-low reset.
- Top-level contents: FSM, counters, credit logic, latency shift register.

## Test plan
- Basic copy, default parameters: `tsrc`=0, `tdst`=16, `tlen`=4, source model returns incrementing data from 0 → writes addr 16..19 with data 0..3 in cycles 3..6; `tdone` in cycle 7.
- `tlen`=0 → `tdone` in cycle 1; no strobes; `tbusy` high for exactly one cycle.
- `RD_LAT`=3, `FIFO_DEPTH`=8, `tlen`=10 → 10 consecutive writes in cycles 5..14; `tdone` in cycle 15.
- Random `v1_wr_ready` (50%), `tlen`=32 → all 32 words written in order with no loss or duplication. Outstanding count (occupancy + in-flight) never exceeds FIFO_DEPTH. `v1_wr_addr`/`v1_wr_data` stable while stalled.
- Wrap: `tsrc`=254, `tdst`=255, `tlen`=3 → reads 254, 255, 0; writes 255, 0, 1.
- `rst_n` low in cycle 4 of a `tlen`=8 run → all outputs 0 immediately. A subsequent launch of `tlen`=2 copies only fresh data.
